// File: rtl/gpu_pkg.sv
// Shared encodings for the compute core: core pipeline states, LSU states
// and the default datapath widths.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/load_store_unit.sv
// Per-thread load/store unit: issues one valid/ready memory transaction per
// LDR/STR and holds the last loaded value for register write-back.
module load_store_unit
  import gpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        core_state,
  input  logic              decoded_mem_read_enable,
  input  logic              decoded_mem_write_enable,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic              mem_read_valid,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic              mem_read_ready,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_write_valid,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic              mem_write_ready,
  output logic [1:0]        lsu_state,
  output logic [DATA_W-1:0] lsu_out
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] lsu_out_q, lsu_out_d;
  logic              is_read_q, is_read_d;
  logic              rvalid_q, rvalid_d;
  logic              wvalid_q, wvalid_d;
  logic [ADDR_W-1:0] addr_ext;
  logic              start;

  // Address operand is truncated or zero-extended to the memory address width.
  if (ADDR_W > DATA_W) begin : g_addr_zext
    assign addr_ext = {{(ADDR_W-DATA_W){1'b0}}, rs};
  end else begin : g_addr_trunc
    assign addr_ext = rs[ADDR_W-1:0];
  end

  assign start = enable && (core_state == CORE_REQUEST) &&
                 (decoded_mem_read_enable || decoded_mem_write_enable);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lsu_out_d = lsu_out_q;
    is_read_d = is_read_q;
    rvalid_d  = rvalid_q;
    wvalid_d  = wvalid_q;
    case (state_q)
      LSU_IDLE: begin
        if (start) begin
          addr_d    = addr_ext;
          is_read_d = decoded_mem_read_enable;
          // A load takes priority; the store half of a dual request is dropped.
          if (!decoded_mem_read_enable) wdata_d = rt;
          state_d = LSU_REQUESTING;
        end
      end
      LSU_REQUESTING: begin
        rvalid_d = is_read_q;
        wvalid_d = !is_read_q;
        state_d  = LSU_WAITING;
      end
      LSU_WAITING: begin
        if (rvalid_q && mem_read_ready) begin
          rvalid_d  = 1'b0;
          lsu_out_d = mem_read_data;
          state_d   = LSU_DONE;
        end else if (wvalid_q && mem_write_ready) begin
          wvalid_d = 1'b0;
          state_d  = LSU_DONE;
        end
      end
      LSU_DONE: begin
        if (core_state == CORE_UPDATE) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LSU_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      lsu_out_q <= '0;
      is_read_q <= 1'b0;
      rvalid_q  <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lsu_out_q <= lsu_out_d;
      is_read_q <= is_read_d;
      rvalid_q  <= rvalid_d;
      wvalid_q  <= wvalid_d;
    end
  end

  // Valids come straight from flops, so ready never reaches them combinationally.
  assign mem_read_valid    = rvalid_q;
  assign mem_write_valid   = wvalid_q;
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;
  assign lsu_state         = state_q;
  assign lsu_out           = lsu_out_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized loads/stores
// checked against a transaction-level expectation of the memory handshake.
module tb_load_store_unit;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_WAIT = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;
  localparam logic [2:0] C_IDLE    = 3'b000;
  localparam logic [2:0] C_REQUEST = 3'b011;
  localparam logic [2:0] C_WAIT    = 3'b100;
  localparam logic [2:0] C_UPDATE  = 3'b110;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] core_state = 3'b000;
  logic       rd_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] rs = 8'h00;
  logic [7:0] rt = 8'h00;
  logic       mem_read_valid;
  logic [7:0] mem_read_address;
  logic       mem_read_ready = 1'b0;
  logic [7:0] mem_read_data = 8'h00;
  logic       mem_write_valid;
  logic [7:0] mem_write_address;
  logic [7:0] mem_write_data;
  logic       mem_write_ready = 1'b0;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_lsu = 8'h00;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .rt                       (rt),
    .mem_read_valid           (mem_read_valid),
    .mem_read_address         (mem_read_address),
    .mem_read_ready           (mem_read_ready),
    .mem_read_data            (mem_read_data),
    .mem_write_valid          (mem_write_valid),
    .mem_write_address        (mem_write_address),
    .mem_write_data           (mem_write_data),
    .mem_write_ready          (mem_write_ready),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag, input logic [1:0] st);
    chk({tag, "_state"}, lsu_state, st);
    chk({tag, "_rvalid"}, mem_read_valid, 1'b0);
    chk({tag, "_wvalid"}, mem_write_valid, 1'b0);
    chk({tag, "_lsu_out"}, lsu_out, exp_lsu);
  endtask

  // One full instruction: start in REQUEST, ready after 'delay' stall cycles,
  // 'hold' extra REQUEST cycles in DONE, then UPDATE.
  task automatic do_op(input logic rd, input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] rdata,
                       input int delay, input int hold, input logic drop_en);
    logic exp_rd;
    logic exp_wr;
    exp_rd = rd;
    exp_wr = !rd;
    enable = 1'b1; rd_en = rd; wr_en = wr; rs = a; rt = d; core_state = C_REQUEST;
    step();
    chk("op_n1", lsu_state, S_REQ);
    chk("op_n1_rvalid", mem_read_valid, 1'b0);
    chk("op_n1_wvalid", mem_write_valid, 1'b0);
    if (drop_en) enable = 1'b0;
    rs = ~a; rt = ~d; rd_en = 1'b0; wr_en = 1'b0; core_state = C_WAIT;
    step();
    chk("op_n2_state", lsu_state, S_WAIT);
    chk("op_n2_rvalid", mem_read_valid, exp_rd);
    chk("op_n2_wvalid", mem_write_valid, exp_wr);
    if (exp_rd) chk("op_n2_raddr", mem_read_address, a);
    else begin
      chk("op_n2_waddr", mem_write_address, a);
      chk("op_n2_wdata", mem_write_data, d);
    end
    for (int i = 0; i < delay; i++) begin
      // Ready on the idle channel must be ignored.
      mem_read_ready  = exp_rd ? 1'b0 : 1'($urandom_range(0, 1));
      mem_write_ready = exp_wr ? 1'b0 : 1'($urandom_range(0, 1));
      mem_read_data   = 8'($urandom);
      step();
      chk("stall_state", lsu_state, S_WAIT);
      chk("stall_rvalid", mem_read_valid, exp_rd);
      chk("stall_wvalid", mem_write_valid, exp_wr);
      if (exp_rd) chk("stall_raddr", mem_read_address, a);
      else begin
        chk("stall_waddr", mem_write_address, a);
        chk("stall_wdata", mem_write_data, d);
      end
      chk("stall_lsu_out", lsu_out, exp_lsu);
    end
    mem_read_ready  = exp_rd;
    mem_write_ready = exp_wr;
    mem_read_data   = exp_rd ? rdata : 8'($urandom);
    step();
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;
    if (exp_rd) exp_lsu = rdata;
    chk_quiet("done", S_DONE);
    enable = 1'b1; rd_en = rd; wr_en = wr; rs = a; core_state = C_REQUEST;
    for (int i = 0; i < hold; i++) begin
      step();
      chk_quiet("hold", S_DONE);
    end
    core_state = C_UPDATE;
    step();
    chk_quiet("update", S_IDLE);
    core_state = C_IDLE; rd_en = 1'b0; wr_en = 1'b0; enable = 1'b0;
  endtask

  initial begin
    logic rnd_rd;
    logic rnd_wr;
    int   kind;

    #12;
    chk_quiet("reset", S_IDLE);
    chk("reset_raddr", mem_read_address, 8'h00);
    chk("reset_wdata", mem_write_data, 8'h00);
    reset = 1'b1;
    step();

    // Basic load, minimum latency
    do_op(1'b1, 1'b0, 8'h2A, 8'h00, 8'h5C, 0, 1, 1'b0);
    // Store stalled for 5 cycles; lsu_out must keep 0x5C
    do_op(1'b0, 1'b1, 8'h10, 8'hF3, 8'h00, 5, 0, 1'b0);
    chk("store_keeps_lsu", lsu_out, 8'h5C);

    // Inactive thread, then a non-memory instruction
    enable = 1'b0; rd_en = 1'b1; wr_en = 1'b0; rs = 8'h44; core_state = C_REQUEST;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_quiet("inactive", S_IDLE);
    end
    enable = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_quiet("nonmem", S_IDLE);
    end
    core_state = C_IDLE; enable = 1'b0;

    // Both enables: read wins; enable dropped mid-operation has no effect
    do_op(1'b1, 1'b1, 8'h77, 8'h99, 8'hA5, 2, 0, 1'b1);
    // DONE hold with REQUEST for 4 cycles
    do_op(1'b1, 1'b0, 8'h03, 8'h00, 8'h3C, 1, 4, 1'b0);

    // Reset asserted mid-wait
    enable = 1'b1; rd_en = 1'b1; rs = 8'hC8; core_state = C_REQUEST;
    step();
    core_state = C_WAIT; rd_en = 1'b0;
    step();
    chk("rstmid_pre_rvalid", mem_read_valid, 1'b1);
    reset = 1'b0;
    #1;
    exp_lsu = 8'h00;
    chk_quiet("rstmid", S_IDLE);
    chk("rstmid_raddr", mem_read_address, 8'h00);
    step();
    chk_quiet("rstmid_hold", S_IDLE);
    #2 reset = 1'b1;
    core_state = C_IDLE; enable = 1'b0;
    step();
    chk_quiet("rstmid_release", S_IDLE);
    do_op(1'b1, 1'b0, 8'hC8, 8'h00, 8'h81, 0, 0, 1'b0);

    // Randomized mix of loads, stores and dual requests
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      rnd_rd = (kind != 1);
      rnd_wr = (kind != 0);
      do_op(rnd_rd, rnd_wr, 8'($urandom), 8'($urandom), 8'($urandom),
            int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
